// File: rtl/axis_packet_sink_if.sv
// rtl/axis_packet_sink_if.sv - AXI-Stream beat channel between the stream master and the packet sink
interface axis_packet_sink_if #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32
);
    logic [C_S_AXIS_TDATA_WIDTH-1:0]     S_AXIS_TDATA;
    logic [(C_S_AXIS_TDATA_WIDTH/8)-1:0] S_AXIS_TSTRB;
    logic                                S_AXIS_TLAST;
    logic                                S_AXIS_TVALID;
    logic                                S_AXIS_TREADY;

    modport master (
        output S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
        input  S_AXIS_TREADY
    );

    modport slave (
        input  S_AXIS_TDATA, S_AXIS_TSTRB, S_AXIS_TLAST, S_AXIS_TVALID,
        output S_AXIS_TREADY
    );
endinterface

// File: rtl/axis_packet_sink.sv
// rtl/axis_packet_sink.sv - AXI-Stream packet sink: FWFT packet FIFO with length cap and protocol checker
module axis_packet_sink #(
    parameter int C_S_AXIS_TDATA_WIDTH = 32,
    parameter int ADDR_W               = 4,
    parameter int MAX_PKT_WORDS        = 16
) (
    input  logic                            S_AXIS_ACLK,
    input  logic                            S_AXIS_ARESETN,
    axis_packet_sink_if.slave               s_axis,
    input  logic                            rd_en,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0] rd_data,
    output logic                            rd_last,
    output logic                            rd_valid,
    output logic                            pkt_avail,
    output logic [7:0]                      pkt_count,
    output logic                            ovf_err,
    output logic                            proto_err
);
    localparam int DW    = C_S_AXIS_TDATA_WIDTH;
    localparam int SW    = DW / 8;
    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [7:0]      MAX_W = 8'(MAX_PKT_WORDS);
    localparam logic [ADDR_W:0] ONE_C = 1;

    typedef enum logic [1:0] {IDLE, IN_PKT, DISCARD} state_t;

    state_t              state;
    logic                armed;
    logic [7:0]          beatcnt;
    logic [ADDR_W-1:0]   wptr, rptr;
    logic [ADDR_W:0]     count, lastcnt;
    logic [DW:0]         mem [DEPTH];
    logic [DW:0]         head;
    logic                full, empty, tready, accept;
    logic                push, push_last, cap, pop, pop_last;
    logic [7:0]          beat_n;
    logic                stall_r, tlast_r;
    logic [DW-1:0]       tdata_r;
    logic [SW-1:0]       tstrb_r;

    // count never exceeds DEPTH, so its top bit alone means full
    assign full   = count[ADDR_W];
    assign empty  = (count == '0);
    assign tready = armed & ((state == DISCARD) | ~full);
    assign accept = s_axis.S_AXIS_TVALID & tready;
    assign s_axis.S_AXIS_TREADY = tready;

    assign head      = mem[rptr];
    assign rd_valid  = ~empty;
    assign rd_data   = empty ? '0 : head[DW-1:0];
    assign rd_last   = ~empty & head[DW];
    assign pkt_avail = (lastcnt != '0);
    assign pop       = rd_en & ~empty;
    assign pop_last  = pop & head[DW];

    // beat_n is the 1-based position of the incoming beat within its packet
    always_comb begin
        beat_n    = (state == IDLE) ? 8'd1 : beatcnt + 8'd1;
        push      = 1'b0;
        push_last = 1'b0;
        cap       = 1'b0;
        if (accept && state != DISCARD) begin
            push      = 1'b1;
            cap       = (beat_n == MAX_W) && !s_axis.S_AXIS_TLAST;
            push_last = s_axis.S_AXIS_TLAST | cap;
        end
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            state   <= IDLE;
            beatcnt <= '0;
            ovf_err <= 1'b0;
        end else if (accept) begin
            case (state)
                IDLE: begin
                    if (cap) begin
                        state   <= DISCARD;
                        ovf_err <= 1'b1;
                    end else if (!s_axis.S_AXIS_TLAST) begin
                        state   <= IN_PKT;
                        beatcnt <= 8'd1;
                    end
                end
                IN_PKT: begin
                    beatcnt <= beat_n;
                    if (s_axis.S_AXIS_TLAST) begin
                        state <= IDLE;
                    end else if (cap) begin
                        state   <= DISCARD;
                        ovf_err <= 1'b1;
                    end
                end
                DISCARD: begin
                    if (s_axis.S_AXIS_TLAST) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge S_AXIS_ACLK) begin
        if (push) mem[wptr] <= {push_last, s_axis.S_AXIS_TDATA};
    end

    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            armed     <= 1'b0;
            wptr      <= '0;
            rptr      <= '0;
            count     <= '0;
            lastcnt   <= '0;
            pkt_count <= '0;
        end else begin
            armed <= 1'b1;
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: ;
            endcase
            case ({push_last, pop_last})
                2'b10:   lastcnt <= lastcnt + ONE_C;
                2'b01:   lastcnt <= lastcnt - ONE_C;
                default: ;
            endcase
            if (push_last) pkt_count <= pkt_count + 8'd1;
        end
    end

    // A stalled beat must be held unchanged until the handshake completes
    always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
        if (!S_AXIS_ARESETN) begin
            stall_r   <= 1'b0;
            tdata_r   <= '0;
            tstrb_r   <= '0;
            tlast_r   <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            stall_r <= armed & s_axis.S_AXIS_TVALID & ~tready;
            tdata_r <= s_axis.S_AXIS_TDATA;
            tstrb_r <= s_axis.S_AXIS_TSTRB;
            tlast_r <= s_axis.S_AXIS_TLAST;
            if (armed && stall_r &&
                (!s_axis.S_AXIS_TVALID || s_axis.S_AXIS_TDATA != tdata_r ||
                 s_axis.S_AXIS_TSTRB != tstrb_r || s_axis.S_AXIS_TLAST != tlast_r))
                proto_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_axis_packet_sink.sv
// tb/tb_axis_packet_sink.sv - scoreboard bench for axis_packet_sink (MAX_PKT_WORDS=8)
module tb_axis_packet_sink;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rd_en = 1'b0;
    logic [31:0] rd_data;
    logic        rd_last, rd_valid, pkt_avail, ovf_err, proto_err;
    logic [7:0]  pkt_count;

    int total = 0;
    int bad   = 0;
    logic [32:0] sb[$];

    axis_packet_sink_if #(.C_S_AXIS_TDATA_WIDTH(32)) s_axis ();

    axis_packet_sink #(
        .C_S_AXIS_TDATA_WIDTH(32),
        .ADDR_W(4),
        .MAX_PKT_WORDS(8)
    ) dut (
        .S_AXIS_ACLK(clk),
        .S_AXIS_ARESETN(rst_n),
        .s_axis(s_axis),
        .rd_en(rd_en),
        .rd_data(rd_data),
        .rd_last(rd_last),
        .rd_valid(rd_valid),
        .pkt_avail(pkt_avail),
        .pkt_count(pkt_count),
        .ovf_err(ovf_err),
        .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic send(input logic [31:0] d, input logic l);
        bit got = 1'b0;
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = d;
        s_axis.S_AXIS_TLAST  = l;
        s_axis.S_AXIS_TSTRB  = 4'hF;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (s_axis.S_AXIS_TREADY) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail("send");
        else begin
            @(posedge clk);
            #1;
        end
        s_axis.S_AXIS_TVALID = 1'b0;
    endtask

    task automatic drain(input string name);
        bit got = 1'b0;
        rd_en = 1'b1;
        for (int c = 0; c < 64; c++) begin
            @(negedge clk);
            if (!rd_valid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) timeout_fail(name);
        rd_en = 1'b0;
        @(posedge clk);
        #1;
        chk({name, "_sb_left"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        s_axis.S_AXIS_TVALID = 1'b0;
        rd_en = 1'b0;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string name);
        chk({name, "_tready"},    {31'b0, s_axis.S_AXIS_TREADY}, 32'd0);
        chk({name, "_rd_valid"},  {31'b0, rd_valid},  32'd0);
        chk({name, "_rd_data"},   rd_data,            32'd0);
        chk({name, "_rd_last"},   {31'b0, rd_last},   32'd0);
        chk({name, "_pkt_avail"}, {31'b0, pkt_avail}, 32'd0);
        chk({name, "_pkt_count"}, {24'b0, pkt_count}, 32'd0);
        chk({name, "_ovf_err"},   {31'b0, ovf_err},   32'd0);
        chk({name, "_proto_err"}, {31'b0, proto_err}, 32'd0);
    endtask

    initial begin
        logic [32:0] exp_w;
        s_axis.S_AXIS_TVALID = 1'b0;
        s_axis.S_AXIS_TDATA  = '0;
        s_axis.S_AXIS_TSTRB  = '0;
        s_axis.S_AXIS_TLAST  = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (rst_n && rd_en && rd_valid) begin
                    if (sb.size() == 0) begin
                        timeout_fail("unexpected_pop");
                    end else begin
                        exp_w = sb.pop_front();
                        chk("rd_data", rd_data, exp_w[31:0]);
                        chk("rd_last", {31'b0, rd_last}, {31'b0, exp_w[32]});
                    end
                end
            end
        join_none

        #1;
        check_all_zero("reset");

        // 8-beat packet, then read back on consecutive cycles
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            chk("t1_tready", {31'b0, s_axis.S_AXIS_TREADY}, 32'd1);
            sb.push_back({(i == 8), 32'(i)});
            send(32'(i), i == 8);
        end
        chk("t1_pkt_avail", {31'b0, pkt_avail}, 32'd1);
        chk("t1_pkt_count", {24'b0, pkt_count}, 32'd1);
        rd_en = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("t1_rd_valid_end", {31'b0, rd_valid},  32'd0);
        chk("t1_pkt_avail_end", {31'b0, pkt_avail}, 32'd0);
        chk("t1_sb_left", 32'(sb.size()), 32'd0);

        // fill to 16, stall beat 17, one pop releases it
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            sb.push_back({(i % 4 == 0), 32'(i)});
            send(32'(i), i % 4 == 0);
        end
        chk("t2_tready_full", {31'b0, s_axis.S_AXIS_TREADY}, 32'd0);
        chk("t2_pkt_count", {24'b0, pkt_count}, 32'd4);
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = 32'd17;
        s_axis.S_AXIS_TLAST  = 1'b0;
        rd_en = 1'b1;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        chk("t2_tready_after_pop", {31'b0, s_axis.S_AXIS_TREADY}, 32'd1);
        sb.push_back({1'b0, 32'd17});
        @(posedge clk);
        #1;
        s_axis.S_AXIS_TVALID = 1'b0;
        chk("t2_tready_full_again", {31'b0, s_axis.S_AXIS_TREADY}, 32'd0);
        drain("t2_drain");
        chk("t2_proto_err", {31'b0, proto_err}, 32'd0);

        // 12-beat packet against an 8-word cap, then a normal 2-beat packet
        do_reset();
        for (int i = 1; i <= 12; i++) begin
            if (i <= 8) sb.push_back({(i == 8), 32'(i)});
            send(32'(i), i == 12);
        end
        chk("t3_ovf_err", {31'b0, ovf_err}, 32'd1);
        chk("t3_pkt_count", {24'b0, pkt_count}, 32'd1);
        sb.push_back({1'b0, 32'hA0});
        sb.push_back({1'b1, 32'hA1});
        send(32'hA0, 1'b0);
        send(32'hA1, 1'b1);
        chk("t3_pkt_count2", {24'b0, pkt_count}, 32'd2);
        drain("t3_drain");
        chk("t3_ovf_sticky", {31'b0, ovf_err}, 32'd1);

        // payload change while stalled
        do_reset();
        for (int i = 1; i <= 16; i++) send(32'(i), i % 4 == 0);
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = 32'h5;
        s_axis.S_AXIS_TLAST  = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_no_err_yet", {31'b0, proto_err}, 32'd0);
        s_axis.S_AXIS_TDATA = 32'h6;
        @(posedge clk);
        #1;
        chk("t4_data_change", {31'b0, proto_err}, 32'd1);
        s_axis.S_AXIS_TVALID = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("t4_sticky", {31'b0, proto_err}, 32'd1);
        do_reset();
        chk("t4_cleared", {31'b0, proto_err}, 32'd0);
        // TVALID withdrawn while stalled
        for (int i = 1; i <= 16; i++) send(32'(i), i % 4 == 0);
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = 32'h5;
        @(posedge clk);
        #1;
        s_axis.S_AXIS_TVALID = 1'b0;
        @(posedge clk);
        #1;
        chk("t4_valid_drop", {31'b0, proto_err}, 32'd1);

        // pop-last and push-last on the same edge
        do_reset();
        sb.push_back({1'b1, 32'h55});
        send(32'h55, 1'b1);
        s_axis.S_AXIS_TVALID = 1'b1;
        s_axis.S_AXIS_TDATA  = 32'h66;
        s_axis.S_AXIS_TLAST  = 1'b1;
        rd_en = 1'b1;
        sb.push_back({1'b1, 32'h66});
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        s_axis.S_AXIS_TVALID = 1'b0;
        chk("t5_pkt_avail", {31'b0, pkt_avail}, 32'd1);
        chk("t5_pkt_count", {24'b0, pkt_count}, 32'd2);
        chk("t5_rd_valid", {31'b0, rd_valid}, 32'd1);
        drain("t5_drain");
        chk("t5_pkt_avail_end", {31'b0, pkt_avail}, 32'd0);

        // asynchronous reset in the middle of a packet
        do_reset();
        send(32'h31, 1'b0);
        send(32'h32, 1'b0);
        send(32'h33, 1'b0);
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        check_all_zero("t6_async");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("t6_tready_unarmed", {31'b0, s_axis.S_AXIS_TREADY}, 32'd0);
        @(posedge clk);
        #1;
        chk("t6_tready_armed", {31'b0, s_axis.S_AXIS_TREADY}, 32'd1);
        sb.push_back({1'b0, 32'h41});
        sb.push_back({1'b1, 32'h42});
        send(32'h41, 1'b0);
        send(32'h42, 1'b1);
        chk("t6_pkt_count", {24'b0, pkt_count}, 32'd1);
        drain("t6_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
